// File: rtl/tilelink_ul_mem_responder_if.sv
// TL-UL Channel A / Channel D bundle between a requester and a responder.
// The master modport is the requester side; the slave modport is the responder side.
interface tilelink_ul_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PARAM_WIDTH  = 3
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    // Channel A
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic                    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    // Channel D
    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic                    d_source;
    logic                    d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );
endinterface

// File: rtl/tilelink_ul_mem_responder.sv
// TL-UL responder backed by a small word-addressed register memory.
// Serves Get/PutFullData/PutPartialData with a single outstanding transaction.
module tilelink_ul_mem_responder #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned           SIZE_WIDTH   = 3,
    parameter int unsigned           OPCODE_WIDTH = 3,
    parameter int unsigned           PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned           MEM_WORDS    = 16,
    parameter int unsigned           RESP_LATENCY = 0
) (
    input logic                        clk,
    input logic                        reset_n,
    tilelink_ul_mem_responder_if.slave tl
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK         = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA    = OPCODE_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] LAT_LOAD = 4'(RESP_LATENCY);

    // One extra bit so the end of the window cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] ADDR_HI = ADDR_LO + (ADDR_WIDTH + 1)'(4 * MEM_WORDS);

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    d_valid_q, d_valid_d;
    logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
    logic [SIZE_WIDTH-1:0]   d_size_q, d_size_d;
    logic                    d_source_q, d_source_d;
    logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
    logic                    d_error_q, d_error_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic [ADDR_WIDTH:0]     addr_ext;
    logic [ADDR_WIDTH-1:0]   addr_off;
    logic [IDX_W-1:0]        word_idx;
    logic                    in_range;
    logic                    size_err;
    logic                    misaligned;
    logic                    is_get;
    logic                    is_put;
    logic                    req_err;
    logic                    accept;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign addr_ext = {1'b0, tl.a_address};
    assign in_range = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);
    assign addr_off = tl.a_address - BASE_ADDR;
    assign word_idx = addr_off[IDX_W+1:2];

    always_comb begin
        size_err   = 1'b0;
        misaligned = 1'b0;
        case (tl.a_size)
            SIZE_WIDTH'(0): misaligned = 1'b0;
            SIZE_WIDTH'(1): misaligned = tl.a_address[0];
            SIZE_WIDTH'(2): misaligned = |tl.a_address[1:0];
            default:        size_err   = 1'b1;
        endcase
    end

    assign is_get  = (tl.a_opcode == OP_GET);
    assign is_put  = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PARTIAL);
    assign req_err = !in_range || size_err || misaligned || !(is_get || is_put);

    assign accept  = (state_q == ST_IDLE) && tl.a_valid;
    assign wr_en   = accept && is_put && !req_err;
    assign rd_word = mem_q[word_idx];

    // ------------------------------------------------------------------
    // Memory: writes complete at the accept edge, so a reset can never tear one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (tl.a_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM and response registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;

        case (state_q)
            ST_IDLE: begin
                if (tl.a_valid) begin
                    // The memory cannot change before the response is sent, so the
                    // read word is captured here regardless of the wait latency.
                    d_opcode_d = is_get ? OP_ACK_DATA : OP_ACK;
                    d_size_d   = tl.a_size;
                    d_source_d = tl.a_source;
                    d_error_d  = req_err;
                    d_data_d   = (is_get && !req_err) ? rd_word : '0;
                    if (RESP_LATENCY == 0) begin
                        state_d   = ST_RESP;
                        d_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    d_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (tl.d_ready) begin
                    state_d   = ST_IDLE;
                    d_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                d_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= 1'b0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tl.a_ready  = (state_q == ST_IDLE);
    assign tl.d_valid  = d_valid_q;
    assign tl.d_opcode = d_opcode_q;
    assign tl.d_param  = '0;
    assign tl.d_size   = d_size_q;
    assign tl.d_source = d_source_q;
    assign tl.d_sink   = 1'b0;
    assign tl.d_data   = d_data_q;
    assign tl.d_error  = d_error_q;

    logic unused_sigs;
    assign unused_sigs = ^{tl.a_param, addr_off[ADDR_WIDTH-1:IDX_W+2], addr_off[1:0]};

endmodule

// File: tb/tb_tilelink_ul_mem_responder.sv
// Directed bench for tilelink_ul_mem_responder: a zero-latency instance for the
// functional vectors and a three-cycle-latency instance for timing and throughput.
module tb_tilelink_ul_mem_responder;

    logic clk;
    logic reset_n;
    logic sel;

    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;

    logic        m_a_ready;
    logic        m_d_valid;
    logic [2:0]  m_d_opcode;
    logic [2:0]  m_d_param;
    logic [2:0]  m_d_size;
    logic        m_d_source;
    logic        m_d_sink;
    logic [31:0] m_d_data;
    logic        m_d_error;

    int checks = 0;
    int errors = 0;

    tilelink_ul_mem_responder_if if0 ();
    tilelink_ul_mem_responder_if if3 ();

    tilelink_ul_mem_responder #(.RESP_LATENCY(0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .tl      (if0.slave)
    );

    tilelink_ul_mem_responder #(.RESP_LATENCY(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .tl      (if3.slave)
    );

    // sel picks which instance sees a_valid/d_ready and drives the observed outputs
    assign if0.a_valid   = a_valid & ~sel;
    assign if3.a_valid   = a_valid & sel;
    assign if0.d_ready   = d_ready & ~sel;
    assign if3.d_ready   = d_ready & sel;
    assign if0.a_opcode  = a_opcode;
    assign if3.a_opcode  = a_opcode;
    assign if0.a_param   = a_param;
    assign if3.a_param   = a_param;
    assign if0.a_size    = a_size;
    assign if3.a_size    = a_size;
    assign if0.a_source  = a_source;
    assign if3.a_source  = a_source;
    assign if0.a_address = a_address;
    assign if3.a_address = a_address;
    assign if0.a_mask    = a_mask;
    assign if3.a_mask    = a_mask;
    assign if0.a_data    = a_data;
    assign if3.a_data    = a_data;

    assign m_a_ready  = sel ? if3.a_ready  : if0.a_ready;
    assign m_d_valid  = sel ? if3.d_valid  : if0.d_valid;
    assign m_d_opcode = sel ? if3.d_opcode : if0.d_opcode;
    assign m_d_param  = sel ? if3.d_param  : if0.d_param;
    assign m_d_size   = sel ? if3.d_size   : if0.d_size;
    assign m_d_source = sel ? if3.d_source : if0.d_source;
    assign m_d_sink   = sel ? if3.d_sink   : if0.d_sink;
    assign m_d_data   = sel ? if3.d_data   : if0.d_data;
    assign m_d_error  = sel ? if3.d_error  : if0.d_error;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        src;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one request, wait for its acceptance and then for d_valid (bounded).
    task automatic issue(input vec_t v, output int lat);
        @(negedge clk);
        a_opcode  = v.op;
        a_size    = v.size;
        a_address = v.addr;
        a_mask    = v.mask;
        a_data    = v.data;
        a_source  = v.src;
        a_param   = 3'd5;
        a_valid   = 1'b1;
        chk("a_ready_idle", 32'(m_a_ready), 32'd1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        lat = 0;
        while (!m_d_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic check_resp(input string name, input vec_t v);
        chk({name, "_d_valid"},  32'(m_d_valid),  32'd1);
        chk({name, "_d_opcode"}, 32'(m_d_opcode), 32'(v.e_op));
        chk({name, "_d_data"},   m_d_data,        v.e_data);
        chk({name, "_d_error"},  32'(m_d_error),  32'(v.e_err));
        chk({name, "_d_source"}, 32'(m_d_source), 32'(v.src));
        chk({name, "_d_size"},   32'(m_d_size),   32'(v.size));
        chk({name, "_d_param"},  32'(m_d_param),  32'd0);
        chk({name, "_d_sink"},   32'(m_d_sink),   32'd0);
        chk({name, "_a_ready"},  32'(m_a_ready),  32'd0);
    endtask

    // d_ready is high here, so the response drains at the next edge
    task automatic finish_resp(input string name);
        @(posedge clk);
        #1;
        chk({name, "_drain_d_valid"}, 32'(m_d_valid), 32'd0);
        chk({name, "_drain_a_ready"}, 32'(m_a_ready), 32'd1);
    endtask

    task automatic run(input string name, input vec_t v, input int exp_lat);
        int lat;
        issue(v, lat);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check_resp(name, v);
        finish_resp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t snap;
        int   lat;
        int   acc [2];
        int   n;

        //            op    size  addr          mask   data          src   e_op  e_data        e_err
        vecs[0]  = '{3'd0, 3'd2, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'h0,        1'b0};
        vecs[1]  = '{3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         1'b0, 3'd1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{3'd1, 3'd2, 32'h0000_1004, 4'h3, 32'h0000_1234, 1'b1, 3'd0, 32'h0,        1'b0};
        vecs[3]  = '{3'd4, 3'd2, 32'h0000_1004, 4'h0, 32'h0,         1'b1, 3'd1, 32'hDEAD_1234, 1'b0};
        vecs[4]  = '{3'd4, 3'd2, 32'h0000_2000, 4'hF, 32'h0,         1'b0, 3'd1, 32'h0,        1'b1};
        vecs[5]  = '{3'd4, 3'd2, 32'h0000_1002, 4'hF, 32'h0,         1'b1, 3'd1, 32'h0,        1'b1};
        vecs[6]  = '{3'd2, 3'd2, 32'h0000_1004, 4'hF, 32'h1111_1111, 1'b0, 3'd0, 32'h0,        1'b1};
        vecs[7]  = '{3'd0, 3'd2, 32'h0000_2000, 4'hF, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'h0,        1'b1};
        vecs[8]  = '{3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         1'b0, 3'd1, 32'hDEAD_1234, 1'b0};
        vecs[9]  = '{3'd0, 3'd2, 32'h0000_1000, 4'h0, 32'h5555_5555, 1'b1, 3'd0, 32'h0,        1'b0};
        vecs[10] = '{3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0,         1'b0, 3'd1, 32'h0,        1'b0};
        vecs[11] = '{3'd0, 3'd2, 32'h0000_103C, 4'hF, 32'hCAFE_F00D, 1'b0, 3'd0, 32'h0,        1'b0};
        vecs[12] = '{3'd4, 3'd2, 32'h0000_1040, 4'hF, 32'h0,         1'b1, 3'd1, 32'h0,        1'b1};
        vecs[13] = '{3'd4, 3'd2, 32'h0000_103C, 4'hF, 32'h0,         1'b1, 3'd1, 32'hCAFE_F00D, 1'b0};
        vecs[14] = '{3'd4, 3'd2, 32'h0000_0FFC, 4'hF, 32'h0,         1'b0, 3'd1, 32'h0,        1'b1};
        vecs[15] = '{3'd4, 3'd1, 32'h0000_1006, 4'hC, 32'h0,         1'b0, 3'd1, 32'hDEAD_1234, 1'b0};
        vecs[16] = '{3'd4, 3'd3, 32'h0000_1000, 4'hF, 32'h0,         1'b1, 3'd1, 32'h0,        1'b1};
        vecs[17] = '{3'd1, 3'd0, 32'h0000_1005, 4'h2, 32'h0000_AB00, 1'b1, 3'd0, 32'h0,        1'b0};
        vecs[18] = '{3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         1'b0, 3'd1, 32'hDEAD_AB34, 1'b0};

        sel       = 1'b0;
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = 1'b0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b1;

        #12;
        chk("reset_a_ready",  32'(m_a_ready),  32'd1);
        chk("reset_d_valid",  32'(m_d_valid),  32'd0);
        chk("reset_d_opcode", 32'(m_d_opcode), 32'd0);
        chk("reset_d_data",   m_d_data,        32'd0);
        chk("reset_d_error",  32'(m_d_error),  32'd0);
        chk("reset_d_source", 32'(m_d_source), 32'd0);
        chk("reset_d_size",   32'(m_d_size),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Backpressure: response held for 5 cycles must not move
        d_ready = 1'b0;
        v = '{3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0, 1'b1, 3'd1, 32'hDEAD_AB34, 1'b0};
        issue(v, lat);
        chk("bp_latency", 32'(lat), 32'd0);
        check_resp("bp_first", v);
        snap = v;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_resp($sformatf("bp_hold%0d", c), snap);
        end
        @(negedge clk);
        d_ready = 1'b1;
        finish_resp("bp_release");

        // Latency-3 instance
        sel = 1'b1;
        @(negedge clk);
        v = '{3'd0, 3'd2, 32'h0000_1008, 4'hF, 32'h1234_5678, 1'b1, 3'd0, 32'h0, 1'b0};
        run("lat3_put", v, 3);
        v = '{3'd4, 3'd2, 32'h0000_1008, 4'hF, 32'h0, 1'b0, 3'd1, 32'h1234_5678, 1'b0};
        run("lat3_get", v, 3);

        // Back-to-back: a_valid held high, record the cycle of each acceptance
        @(negedge clk);
        a_opcode  = 3'd4;
        a_size    = 3'd2;
        a_address = 32'h0000_1000;
        a_valid   = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 2; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (m_a_ready) begin
                acc[n] = cyc;
                n++;
            end
        end
        @(posedge clk);
        #1 a_valid = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd2);
        if (n == 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd5);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_idle_a_ready", 32'(m_a_ready), 32'd1);
        chk("b2b_idle_d_valid", 32'(m_d_valid), 32'd0);

        // Asynchronous reset while a response is pending
        sel = 1'b0;
        d_ready = 1'b0;
        v = '{3'd4, 3'd2, 32'h0000_103C, 4'hF, 32'h0, 1'b1, 3'd1, 32'hCAFE_F00D, 1'b0};
        issue(v, lat);
        check_resp("pre_rst", v);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", 32'(m_d_valid), 32'd0);
        chk("mid_rst_a_ready", 32'(m_a_ready), 32'd1);
        d_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        v = '{3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0, 1'b0, 3'd1, 32'h0, 1'b0};
        run("post_rst_1004", v, 0);
        v = '{3'd4, 3'd2, 32'h0000_103C, 4'hF, 32'h0, 1'b1, 3'd1, 32'h0, 1'b0};
        run("post_rst_103c", v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tilelink_ul_mem_responder.md
Name: tilelink_ul_mem_responder

Overview:
TL-UL slave (responder) terminating Channel A and generating Channel D in the 24 MHz domain, on the far side of the clock-domain-crossing adapter. It owns a small word-addressed register memory and serves Get, PutFullData and PutPartialData requests. It answers with AccessAckData or AccessAck, flagging decode, alignment and opcode errors. Only one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (32 only)
MASK_WIDTH, DATA_WIDTH/8, byte-mask width
SIZE_WIDTH, 3, a_size/d_size width
OPCODE_WIDTH, 3, opcode width
PARAM_WIDTH, 3, param width
BASE_ADDR, 32'h0000_1000, first byte address served
MEM_WORDS, 16, number of DATA_WIDTH words (power of two)
RESP_LATENCY, 0, extra wait cycles between accept and d_valid (0..15)

Ports:
clk  in  1  24 MHz clock
reset_n  in  1  asynchronous active-low reset
a_valid  in  1  request valid
a_ready  out  1  request accepted when high with a_valid
a_opcode  in  OPCODE_WIDTH  0=PutFull, 1=PutPartial, 4=Get
a_param  in  PARAM_WIDTH  ignored
a_size  in  SIZE_WIDTH  log2 bytes
a_source  in  1  requester ID
a_address  in  ADDR_WIDTH  byte address
a_mask  in  MASK_WIDTH  byte lanes
a_data  in  DATA_WIDTH  write data
d_valid  out  1  response valid
d_ready  in  1  response accepted
d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
d_param  out  PARAM_WIDTH  always 0
d_size  out  SIZE_WIDTH  echo of a_size
d_source  out  1  echo of a_source
d_sink  out  1  always 0
d_data  out  DATA_WIDTH  read data, 0 for writes and errors
d_error  out  1  denied/corrupt flag

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Naming follows the codebase: clk, reset_n.
- Reset values: FSM=IDLE, a_ready=1, d_valid=0, every d_* output =0, wait counter =0, all memory words =0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: a_ready=1. On handshake at edge k, latch source, size and opcode, and decode.
  - If RESP_LATENCY=0, go to RESP at edge k. Otherwise go to WAIT and load the counter with RESP_LATENCY.
  - WAIT: a_ready=0. Decrement the counter each cycle. At 1, go to RESP.
  - Result: d_valid rises at edge k+RESP_LATENCY, i.e. it is visible in the cycle after edge k when RESP_LATENCY=0.
  - RESP: a_ready=0. All d_* outputs are registered and held stable while d_valid=1 and d_ready=0. On d_valid&&d_ready go to IDLE, clear d_valid, and raise a_ready at the same edge.
  - Minimum throughput: one transaction per 2+RESP_LATENCY cycles.
- Decode and error rules (evaluated at accept):
  - Valid address: BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS.
  - Word index = (addr-BASE_ADDR)>>2, width log2(MEM_WORDS).
  - Error if any of: address out of range; a_size>2; addr not aligned to 2^a_size; opcode not in {0,1,4}.
- Error response: no memory change, d_error=1, d_data=0. d_opcode=1 for a Get, else 0.
- Writes (opcode 0/1, no error):
  - Bytes whose mask bit is set are written at the accept edge. Lanes with mask 0 are unchanged.
  - Mask=0 is legal: no write, AccessAck, d_error=0.
  - Response: d_opcode=0, d_data=0.
- Get (no error): d_opcode=1. d_data is the full addressed word sampled when the response is loaded; the mask is ignored.
- Ordering: a read following a write to the same word returns the written data; this follows from the serial FSM.
- Mid-operation reset (any state): immediately IDLE with d_valid=0. No partial write is possible because writes complete at the accept edge.
- a_valid is ignored outside IDLE. d_ready is ignored when d_valid=0.

Test Plan:
- Reset, then PutFull addr=0x1004 data=0xDEADBEEF mask=0xF src=1 -> one cycle later d_valid=1, d_opcode=0, d_source=1, d_error=0. Then Get 0x1004 -> d_opcode=1, d_data=0xDEADBEEF, d_size=2.
- PutPartial addr=0x1004 mask=0x3 data=0x00001234 over 0xDEADBEEF -> Get returns 0xDEAD1234.
- Get 0x2000 (out of range), Get 0x1002 with size=2 (misaligned), and opcode=2 -> each d_error=1, d_data=0, memory unchanged.
- Backpressure: hold d_ready=0 for 5 cycles after a Get -> d_* outputs stable, a_ready=0 throughout. Release -> a_ready=1 on the same edge d_valid falls.
- RESP_LATENCY=3: accept at edge k -> d_valid first high after edge k+3. Back-to-back requests -> accepts spaced 5 cycles apart.
- Assert reset_n=0 during RESP -> d_valid=0 and a_ready=1 asynchronously. Get 0x1004 after release -> 0x00000000.
